// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: base opcodes, control-unit states and the
// control-strobe bundle driven by the multicycle sequencer.
package riscv_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP_RG3 = 7'b0110011,
    SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WB    = 2'd2,
    INTR  = 2'd3
  } state_t;

  localparam logic [2:0] FUNC3_MRET = 3'b000;

  typedef struct packed {
    logic pc_write;
    logic ir_we;
    logic reg_write;
    logic mem_rden1;
    logic mem_rden2;
    logic mem_we2;
    logic csr_we;
    logic int_taken;
    logic mret_exec;
    logic illegal_op;
    logic mem_err;
  } ctrl_t;

endpackage

// File: rtl/cu_fsm_if.sv
// Control-unit boundary: decoded IR fields and memory handshake in,
// write enables and status pulses out.
interface cu_fsm_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       int_req;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_we;
    logic       reg_write;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  opcode, func3, int_req, mem_ready,
        output pc_write, ir_we, reg_write, mem_rden1, mem_rden2, mem_we2,
               csr_we, int_taken, mret_exec, illegal_op, mem_err
    );

    modport slave (
        output opcode, func3, int_req, mem_ready,
        input  pc_write, ir_we, reg_write, mem_rden1, mem_rden2, mem_we2,
               csr_we, int_taken, mret_exec, illegal_op, mem_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter; `expired` is high on the last permitted
// waiting cycle so the sequencer can flag a timeout in that same cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/cu_fsm.sv
// Multicycle RISC-V control unit: sequences fetch, execute, load writeback
// and interrupt entry, with bounded memory wait states.
module cu_fsm
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst,
    cu_fsm_if.master  bus
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   timer_clr;
    logic   timer_en;
    logic   expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        ctrl       = '0;
        next_state = state;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;

        unique case (state)
            FETCH: begin
                ctrl.mem_rden1 = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    timer_clr  = 1'b1;
                    next_state = EXEC;
                end else if (expired) begin
                    // Timeout re-issues the fetch rather than leaving FETCH.
                    ctrl.mem_err = 1'b1;
                    timer_clr    = 1'b1;
                end else begin
                    timer_en = 1'b1;
                end
            end

            EXEC: begin
                timer_clr  = 1'b1;
                next_state = bus.int_req ? INTR : FETCH;
                case (bus.opcode)
                    LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.pc_write  = 1'b1;
                    end
                    BRANCH: ctrl.pc_write = 1'b1;
                    STORE: begin
                        ctrl.mem_we2  = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    LOAD: begin
                        ctrl.mem_rden2 = 1'b1;
                        next_state     = WB;
                    end
                    SYS: begin
                        ctrl.pc_write = 1'b1;
                        if (bus.func3 == FUNC3_MRET) begin
                            ctrl.mret_exec = 1'b1;
                        end else begin
                            ctrl.csr_we    = 1'b1;
                            ctrl.reg_write = 1'b1;
                        end
                    end
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        ctrl.pc_write   = 1'b1;
                    end
                endcase
            end

            WB: begin
                ctrl.mem_rden2 = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    timer_clr      = 1'b1;
                    next_state     = bus.int_req ? INTR : FETCH;
                end else if (expired) begin
                    // A failed load still retires; any interrupt waits one instruction.
                    ctrl.mem_err  = 1'b1;
                    ctrl.pc_write = 1'b1;
                    timer_clr     = 1'b1;
                    next_state    = FETCH;
                end else begin
                    timer_en = 1'b1;
                end
            end

            INTR: begin
                ctrl.int_taken = 1'b1;
                ctrl.pc_write  = 1'b1;
                timer_clr      = 1'b1;
                next_state     = FETCH;
            end

            default: next_state = FETCH;
        endcase

        if (rst) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_we      = ctrl.ir_we;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_rden1  = ctrl.mem_rden1;
    assign bus.mem_rden2  = ctrl.mem_rden2;
    assign bus.mem_we2    = ctrl.mem_we2;
    assign bus.csr_we     = ctrl.csr_we;
    assign bus.int_taken  = ctrl.int_taken;
    assign bus.mret_exec  = ctrl.mret_exec;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.mem_err    = ctrl.mem_err;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: walks each instruction class, wait states,
// timeouts, interrupt entry and reset mid-load, checking all strobes per cycle.
module tb_cu_fsm;
    import riscv_pkg::*;

    localparam logic [10:0] PC   = 11'b100_0000_0000;
    localparam logic [10:0] IR   = 11'b010_0000_0000;
    localparam logic [10:0] RW   = 11'b001_0000_0000;
    localparam logic [10:0] RD1  = 11'b000_1000_0000;
    localparam logic [10:0] RD2  = 11'b000_0100_0000;
    localparam logic [10:0] WE2  = 11'b000_0010_0000;
    localparam logic [10:0] CSR  = 11'b000_0001_0000;
    localparam logic [10:0] INTA = 11'b000_0000_1000;
    localparam logic [10:0] MRET = 11'b000_0000_0100;
    localparam logic [10:0] ILL  = 11'b000_0000_0010;
    localparam logic [10:0] ERR  = 11'b000_0000_0001;
    localparam logic [10:0] NONE = 11'b000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cu_fsm_if bus ();

    cu_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wire [10:0] outs = {bus.pc_write, bus.ir_we, bus.reg_write, bus.mem_rden1,
                        bus.mem_rden2, bus.mem_we2, bus.csr_we, bus.int_taken,
                        bus.mret_exec, bus.illegal_op, bus.mem_err};

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("%s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check before the rising edge.
    task automatic cyc(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic irq, input logic rdy, input logic r,
                       input logic [10:0] exp);
        @(negedge clk);
        bus.opcode    = op;
        bus.func3     = f3;
        bus.int_req   = irq;
        bus.mem_ready = rdy;
        rst           = r;
        #1;
        check(tag, outs, exp);
    endtask

    opcode_t alu_ops [5] = '{LUI, AUIPC, JAL, JALR, OP_RG3};

    initial begin
        bus.opcode = OP_IMM; bus.func3 = 3'b000; bus.int_req = 1'b0; bus.mem_ready = 1'b0;

        cyc("rst_c0", OP_IMM, 3'd0, 1'b1, 1'b1, 1'b1, NONE);
        cyc("rst_c1", OP_IMM, 3'd0, 1'b1, 1'b1, 1'b1, NONE);

        cyc("opimm_fetch", OP_IMM, 3'd0, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("opimm_exec",  OP_IMM, 3'd0, 1'b0, 1'b1, 1'b0, RW | PC);

        foreach (alu_ops[i]) begin
            cyc($sformatf("alu%0d_fetch", i), alu_ops[i], 3'd0, 1'b0, 1'b1, 1'b0, RD1 | IR);
            cyc($sformatf("alu%0d_exec", i),  alu_ops[i], 3'd0, 1'b0, 1'b0, 1'b0, RW | PC);
        end

        cyc("load_fetch", LOAD, 3'd2, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("load_exec",  LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD2);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("load_wait%0d", i), LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD2);
        cyc("load_done",  LOAD, 3'd2, 1'b0, 1'b1, 1'b0, RD2 | RW | PC);

        cyc("store_fetch", STORE, 3'd2, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("store_exec",  STORE, 3'd2, 1'b1, 1'b0, 1'b0, WE2 | PC);
        cyc("store_intr",  STORE, 3'd2, 1'b1, 1'b1, 1'b0, INTA | PC);

        cyc("mret_fetch_irq", SYS, 3'd0, 1'b1, 1'b1, 1'b0, RD1 | IR);
        cyc("mret_exec",      SYS, 3'd0, 1'b0, 1'b0, 1'b0, MRET | PC);
        cyc("csrrw_fetch",    SYS, 3'd1, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("csrrw_exec",     SYS, 3'd1, 1'b0, 1'b0, 1'b0, CSR | RW | PC);

        for (int i = 1; i <= 40; i++)
            cyc($sformatf("fetch_to%0d", i), BRANCH, 3'd0, 1'b0, 1'b0, 1'b0,
                (i == 16 || i == 32) ? (RD1 | ERR) : RD1);
        cyc("branch_fetch", BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("branch_exec",  BRANCH, 3'd0, 1'b0, 1'b0, 1'b0, PC);

        cyc("ldto_fetch", LOAD, 3'd2, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("ldto_exec",  LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD2);
        for (int i = 1; i <= 16; i++)
            cyc($sformatf("wb_to%0d", i), LOAD, 3'd2, 1'b1, 1'b0, 1'b0,
                (i == 16) ? (RD2 | ERR | PC) : RD2);
        cyc("post_to_fetch_wait", 7'b1111111, 3'd0, 1'b1, 1'b0, 1'b0, RD1);
        cyc("ill_fetch",          7'b1111111, 3'd0, 1'b1, 1'b1, 1'b0, RD1 | IR);
        cyc("ill_exec",           7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, ILL | PC);

        cyc("rstwb_fetch", LOAD, 3'd2, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("rstwb_exec",  LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD2);
        cyc("rstwb_wait",  LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD2);
        cyc("rstwb_rst",   LOAD, 3'd2, 1'b1, 1'b1, 1'b1, NONE);
        cyc("rstwb_after", LOAD, 3'd2, 1'b0, 1'b0, 1'b0, RD1);
        cyc("rstwb_refetch", OP_IMM, 3'd0, 1'b0, 1'b1, 1'b0, RD1 | IR);
        cyc("rstwb_reexec",  OP_IMM, 3'd0, 1'b0, 1'b0, 1'b0, RW | PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
